alu_ctrl_8bit: RTL and testbench
================================

// Module: alu_ctrl_8bit
// PURPOSE
//  Operand/control sequencer directly upstream of alu_8bit. Accepts 16-bit instructions over a
//  valid/ready handshake and holds a 4x8 register file. Drives alu_8bit's a, b and alu_sel from
//  registers, then captures alu_out/carry_out back into the register file and the flags.
//  One instruction is in flight at a time; there is no pipelining.
// PARAMETERS
//  DATA_W   8   datapath width; fixed by alu_8bit
//  REG_AW   2   register address width (2**REG_AW = 4 registers)
//  INSTR_W  16  instruction width
// PORTS
//  clk          in   1       single clock; all state updates on posedge
//  rst_n        in   1       reset: synchronous, active-low
//  instr        in   16      [15]=li, [14:12]=alu_sel, [11:10]=rd, [9:8]=rs1, [7:6]=rs2, [7:0]=imm (li only)
//  instr_valid  in   1       instr is valid this cycle
//  instr_ready  out  1       block can accept an instruction (high only in IDLE)
//  alu_a        out  8       to alu_8bit a; registered
//  alu_b        out  8       to alu_8bit b; registered
//  alu_sel      out  3       to alu_8bit alu_sel; registered
//  alu_result   in   8       from alu_8bit alu_out; combinational
//  alu_carry    in   1       from alu_8bit carry_out
//  carry_flag   out  1       carry of the last ALU instruction
//  zero_flag    out  1       high when the last ALU result == 0
//  done         out  1       one-cycle pulse when the instruction retires
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//   - state=IDLE; regs R0..R3=0; alu_a=alu_b=0; alu_sel=0; flags=0; done=0.
//   - Reset overrides any in-flight instruction: no write-back, no done.
//  FSM:
//   - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr. If li=1 go to WB, else go to OPER.
//   - OPER: alu_a<=R[rs1]; alu_b<=R[rs2]; alu_sel<=instr[14:12]. Go to EXEC.
//   - EXEC: ALU inputs are stable. At the end of EXEC, latch alu_result/alu_carry. Go to WB.
//   - WB:
//     - li=0: R[rd]<=latched result; carry_flag<=latched carry; zero_flag<=(result==0).
//     - li=1: R[rd]<=imm; flags unchanged.
//     - done=1 for this cycle only. Go to IDLE.
//  Latency (handshake cycle = 0):
//   - ALU op: done in cycle 3, R[rd] visible in cycle 4; throughput 1 instr / 4 cycles.
//   - li: done in cycle 1.
//  Handshake:
//   - instr_ready is low in OPER, EXEC and WB; instr_valid in those states is ignored.
//   - The sender must hold instr stable until accepted.
//  Boundaries:
//   - rs1==rs2 is legal; both operands equal R[rs1].
//   - rd==rs1 or rd==rs2: operands were sampled in OPER, so the new write does not affect them.
//   - Back-to-back dependency: the next instruction's OPER reads the value written in the prior WB.
//   - Any alu_sel code 000..111 is passed through unchecked.
//   - alu_a, alu_b and alu_sel hold their values outside OPER.
//   - done never asserts in two consecutive cycles.
// CONFIGURATION
//  CTRL_DBG_PORT_EN defined:
//   - Adds dbg_addr (in, 2) and dbg_data (out, 8); dbg_data = R[dbg_addr], combinational, read-only.
//   - dbg_data shows the WB write the cycle after WB.
//  CTRL_DBG_PORT_EN undefined:
//   - Ports absent; behaviour otherwise identical.
// STRUCTURE
//  Package alu_ctrl_pkg:
//   - state enum {IDLE, OPER, EXEC, WB}.
//   - Instruction field bit positions.
//   - DATA_W and REG_AW constants.
//  Sub-module ctrl_regfile:
//   - 4x8, synchronous single write port; 2 async read ports (3 with CTRL_DBG_PORT_EN); reset to 0.
//  The FSM and flag logic live in alu_ctrl_8bit.
// TESTING
//  Bench instantiates a behavioural ALU model on alu_a/alu_b/alu_sel and checks every transfer.
//  1. Reset/li:
//     - rst_n=0 for 2 cycles: all outputs 0, instr_ready=1.
//     - li R1=0x6F (instr=16'h846F): done in cycle 1; R1==0x6F.
//  2. ALU op:
//     - R1=R2=0x6F, instr sel=000, rd=3, rs1=1, rs2=2 -> in EXEC alu_a=0x6F, alu_b=0x6F, alu_sel=000.
//     - Model returns 0xDE, carry 0 -> R3=0xDE, carry_flag=0, zero_flag=0; done in cycle 3.
//  3. Flags: model returns 0x00, carry 1 -> zero_flag=1, carry_flag=1; a following li leaves both flags unchanged.
//  4. Handshake: hold instr_valid=1 through a 4-cycle op -> exactly one accept per IDLE; instr_ready low for cycles 1-3.
//  5. Hazard/reset:
//     - rd=rs1=1: the operand is the old R1; a back-to-back dependent op sees the new value.
//     - rst_n=0 during EXEC: no write, no done, state=IDLE.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the alu_8bit operand/control sequencer.
// Holds the FSM state encoding, instruction field positions and a decode helper.
package alu_ctrl_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 2;
  localparam int INSTR_W  = 16;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int SEL_W    = 3;

  // Instruction field bit positions. imm overlaps rs2 and is only meaningful for li.
  localparam int LI_BIT = 15;
  localparam int SEL_HI = 14;
  localparam int SEL_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic              li;
    logic [SEL_W-1:0]  sel;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Split a raw instruction word into its named fields.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.li  = raw[LI_BIT];
    d.sel = raw[SEL_HI:SEL_LO];
    d.rd  = raw[RD_HI:RD_LO];
    d.rs1 = raw[RS1_HI:RS1_LO];
    d.rs2 = raw[RS2_HI:RS2_LO];
    d.imm = raw[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/ctrl_regfile.sv
// 4x8 register file for alu_ctrl_8bit: one synchronous write port, two
// asynchronous read ports, plus a third debug read port when
// CTRL_DBG_PORT_EN is defined. All entries clear on synchronous reset.
module ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2
`ifdef CTRL_DBG_PORT_EN
  ,
  input  logic [REG_AW-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data3
`endif
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage: clear on reset, single write per cycle otherwise.
  // NOTE: this array is only four words built from flops, so clearing it in
  // reset is cheap; a RAM-mapped array must not be reset this way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

`ifdef CTRL_DBG_PORT_EN
  assign rd_data3 = regs[rd_addr3];
`endif

endmodule

// File: rtl/alu_ctrl_8bit.sv
// Operand/control sequencer sitting directly upstream of alu_8bit.
// Accepts one 16-bit instruction at a time over valid/ready, feeds registered
// operands to the ALU, and writes the result and flags back.
// Optional feature macro: CTRL_DBG_PORT_EN adds a read-only register peek port
// (dbg_addr / dbg_data).
module alu_ctrl_8bit
  import alu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  output logic               carry_flag,
  output logic               zero_flag,
  output logic               done
`ifdef CTRL_DBG_PORT_EN
  ,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
`endif
);

  state_e            state;
  state_e            state_nxt;
  instr_t            ir;
  logic [DATA_W-1:0] res_q;
  logic              carry_q;
  logic              accept;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Retire pulse; masked while reset is asserted so an in-flight WB never reports.
  assign done    = (state == WB) && rst_n;
  assign wr_en   = (state == WB);
  assign wr_data = ir.li ? ir.imm : res_q;

  // State register.
  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: li skips straight to write-back, ALU ops take OPER and EXEC.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = instr[LI_BIT] ? WB : OPER;
        end
      end
      OPER:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch instruction, drive ALU operands, capture result, update flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir         <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      if (accept) begin
        ir <= decode_instr(instr);
      end
      if (state == OPER) begin
        alu_a   <= rs1_data;
        alu_b   <= rs2_data;
        alu_sel <= ir.sel;
      end
      if (state == EXEC) begin
        res_q   <= alu_result;
        carry_q <= alu_carry;
      end
      if (state == WB && !ir.li) begin
        carry_flag <= carry_q;
        zero_flag  <= (res_q == '0);
      end
    end
  end

  ctrl_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (ir.rd),
    .wr_data  (wr_data),
    .rd_addr1 (ir.rs1),
    .rd_data1 (rs1_data),
    .rd_addr2 (ir.rs2),
    .rd_data2 (rs2_data)
`ifdef CTRL_DBG_PORT_EN
    ,
    .rd_addr3 (dbg_addr),
    .rd_data3 (dbg_data)
`else
`endif
  );

endmodule

// File: tb/tb_alu_ctrl_8bit.sv
// Self-checking bench for alu_ctrl_8bit. A behavioural ALU answers on
// alu_a/alu_b/alu_sel; an array-based reference model predicts registers,
// operands and flags from the instruction stream.
module tb_alu_ctrl_8bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        carry_flag;
  logic        zero_flag;
  logic        done;
`ifdef CTRL_DBG_PORT_EN
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  alu_ctrl_8bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .done        (done)
`ifdef CTRL_DBG_PORT_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
    logic [7:0] t;
    case (sel)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: begin t = a - b; return {(a < b), t}; end
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: begin t = a << 1; return {a[7], t}; end
      default: begin t = a >> 1; return {a[0], t}; end
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_sel);

  // Reference model state.
  logic [7:0] ref_r [4];
  logic [7:0] ref_a, ref_b;
  logic [2:0] ref_sel;
  logic       ref_c, ref_z;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       c;
    logic       z;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  sel;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_a = 8'h00; ref_b = 8'h00; ref_sel = 3'd0; ref_c = 1'b0; ref_z = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] ins);
    logic [8:0] r;
    if (ins[15]) begin
      ref_r[ins[11:10]] = ins[7:0];
    end else begin
      ref_a   = ref_r[ins[9:8]];
      ref_b   = ref_r[ins[7:6]];
      ref_sel = ins[14:12];
      r       = alu_fn(ref_a, ref_b, ref_sel);
      ref_r[ins[11:10]] = r[7:0];
      ref_c   = r[8];
      ref_z   = (r[7:0] == 8'h00);
    end
  endtask

  // Issue one instruction, check done/ready timing, return post-retire outputs.
  task automatic run_instr(input logic [15:0] ins, output obs_t o);
    int w = 0;
    while (!instr_ready && w < 8) begin
      tick();
      w++;
    end
    if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = $urandom;
    if (ins[15]) begin
      check("li_done_c1", done, 1);
      check("li_ready_c1", instr_ready, 0);
    end else begin
      check("op_c1_done_ready", {done, instr_ready}, 0);
      tick();
      check("op_c2_done_ready", {done, instr_ready}, 0);
      check("op_c2_exec_a", alu_a, ref_r[ins[9:8]]);
      check("op_c2_exec_b", alu_b, ref_r[ins[7:6]]);
      tick();
      check("op_done_c3", done, 1);
      check("op_ready_c3", instr_ready, 0);
    end
    tick();
    check("retire_done_low", done, 0);
    check("retire_ready", instr_ready, 1);
    model_apply(ins);
    o.a = alu_a; o.b = alu_b; o.sel = alu_sel; o.c = carry_flag; o.z = zero_flag;
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sel,
                         input logic c, input logic z);
    check({tag, "_alu_a"}, o.a, a);
    check({tag, "_alu_b"}, o.b, b);
    check({tag, "_alu_sel"}, o.sel, sel);
    check({tag, "_carry"}, o.c, c);
    check({tag, "_zero"}, o.z, z);
  endtask

  initial begin
    obs_t o;
    logic [15:0] ins;

    // Directed sequence: li, add, zero/carry, li flag hold, hazards, sel=111.
    vecs[0]  = '{16'h846F, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // li R1=6F
    vecs[1]  = '{16'h886F, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // li R2=6F
    vecs[2]  = '{16'h0D80, 8'h6F, 8'h6F, 3'd0, 1'b0, 1'b0}; // R3=R1+R2=DE
    vecs[3]  = '{16'h8080, 8'h6F, 8'h6F, 3'd0, 1'b0, 1'b0}; // li R0=80
    vecs[4]  = '{16'h8480, 8'h6F, 8'h6F, 3'd0, 1'b0, 1'b0}; // li R1=80
    vecs[5]  = '{16'h0840, 8'h80, 8'h80, 3'd0, 1'b1, 1'b1}; // R2=R0+R1=00 c=1
    vecs[6]  = '{16'h8055, 8'h80, 8'h80, 3'd0, 1'b1, 1'b1}; // li R0=55, flags held
    vecs[7]  = '{16'h2780, 8'hDE, 8'h00, 3'd2, 1'b0, 1'b1}; // R1=R3&R2=00
    vecs[8]  = '{16'h8410, 8'hDE, 8'h00, 3'd2, 1'b0, 1'b1}; // li R1=10
    vecs[9]  = '{16'h0540, 8'h10, 8'h10, 3'd0, 1'b0, 1'b0}; // R1=R1+R1=20
    vecs[10] = '{16'h0D00, 8'h20, 8'h55, 3'd0, 1'b0, 1'b0}; // R3=R1+R0=75
    vecs[11] = '{16'h7380, 8'h75, 8'h00, 3'd7, 1'b1, 1'b0}; // R0=R3>>1=3A c=1

    rst_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0;
`ifdef CTRL_DBG_PORT_EN
    dbg_addr = 2'd0;
`endif
    model_reset();
    tick();
    tick();
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_flags", {carry_flag, zero_flag}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].ins, o);
      cmp_obs($sformatf("vec%0d", i), o, vecs[i].a, vecs[i].b, vecs[i].sel,
              vecs[i].c, vecs[i].z);
    end

    // Handshake: valid held high through three ops; one accept per IDLE.
    ins = 16'h0500; // R1 = R1 + R0
    instr = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("hs_ready_c%0d", i), instr_ready, (i % 4) == 0);
      check($sformatf("hs_done_c%0d", i), done, (i % 4) == 3);
      tick();
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) model_apply(ins);
    check("hs_alu_a", alu_a, ref_a);
    check("hs_carry", carry_flag, ref_c);
    check("hs_zero", zero_flag, ref_z);

    // Reset during EXEC: no done, back to IDLE, everything cleared.
    run_instr(16'h8833, o); // li R2=33
    instr = 16'h0A80;       // R2 = R2 + R2
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rexec_done", done, 0);
    check("rexec_ready", instr_ready, 1);
    check("rexec_alu_a", alu_a, 0);
    rst_n = 1'b1;
    tick();
    check("rexec_no_late_done", done, 0);
    model_reset();
    run_instr(16'h0E80, o); // R3 = R2 + R2: must read cleared R2
    cmp_obs("rexec_after", o, ref_a, ref_b, ref_sel, ref_c, ref_z);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 9) < 4) ins[15] = 1'b1;
      else ins[15] = 1'b0;
      run_instr(ins, o);
      cmp_obs($sformatf("rnd%0d", n), o, ref_a, ref_b, ref_sel, ref_c, ref_z);
`ifdef CTRL_DBG_PORT_EN
      dbg_addr = ins[11:10];
      #1;
      check("dbg_data", dbg_data, ref_r[ins[11:10]]);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
